// File: rtl/camera_pkg.sv
// Shared constants, FSM encoding and report-byte builder for the IR camera emulator.
package camera_pkg;

    localparam logic [6:0] CAM_I2C_ADDR = 7'h58;
    localparam logic [7:0] REG_CONF_30  = 8'h30;
    localparam logic [7:0] REG_MODE_33  = 8'h33;
    localparam logic [7:0] REG_REPORT   = 8'h36;
    localparam int         REPORT_LEN   = 16;
    localparam logic [7:0] FILL_BYTE    = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE,
        ST_IDLE_WAIT
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] size;
        logic       valid;
    } blob_t;

    // Byte returned for a read at ptr; anything outside the report window reads as 0x00.
    function automatic logic [7:0] report_byte(input logic [7:0] ptr, input logic [7:0] base,
                                               input int len, input blob_t b);
        logic [7:0] k;
        logic [7:0] result;
        k = ptr - base;
        result = 8'h00;
        if (int'(k) < len && k != 8'd0) begin
            if (!b.valid) begin
                result = FILL_BYTE;
            end else begin
                case (k)
                    8'd1:    result = b.x[7:0];
                    8'd2:    result = b.y[7:0];
                    8'd3:    result = {b.y[9:8], b.x[9:8], b.size};
                    default: result = FILL_BYTE;
                endcase
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/camera_emulator_if.sv
// Pin-level I2C bus, blob position inputs and configuration outputs of the camera emulator.
interface camera_emulator_if;
    logic       i2c_scl;
    logic       i2c_sda_in;
    logic       i2c_sda;
    logic       i2c_sda_dir;
    logic [9:0] blob_x;
    logic [9:0] blob_y;
    logic [3:0] blob_size;
    logic       blob_valid;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] cfg_30;
    logic [7:0] cfg_33;

    modport slave (
        input  i2c_scl, i2c_sda_in, blob_x, blob_y, blob_size, blob_valid,
        output i2c_sda, i2c_sda_dir, cfg_we, cfg_addr, cfg_data, cfg_30, cfg_33
    );

    modport master (
        output i2c_scl, i2c_sda_in, blob_x, blob_y, blob_size, blob_valid,
        input  i2c_sda, i2c_sda_dir, cfg_we, cfg_addr, cfg_data, cfg_30, cfg_33
    );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // NOTE: these flops reset to 1 (idle bus level) so leaving reset never fakes an edge or START.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync[0] <= scl;
            sda_sync[0] <= sda;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/camera_emulator.sv
// I2C responder standing in for the IR position camera: takes config writes, serves position reports.
module camera_emulator
    import camera_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = CAM_I2C_ADDR,
    parameter logic [7:0] READ_BASE   = REG_REPORT,
    parameter int         READ_LEN    = REPORT_LEN,
    parameter int         SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              reset,
    camera_emulator_if.slave bus
);
    logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
    state_t     state, state_nxt;
    logic [7:0] shift;
    logic [7:0] pointer;
    logic [3:0] bit_cnt;
    logic       byte_done;
    logic       rw;
    logic       byte_index;
    logic       master_ack;
    blob_t      snap;
    logic       sda_dir;
    logic       cfg_we;
    logic [7:0] cfg_addr, cfg_data, cfg_30, cfg_33;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_bus_monitor (
        .clk       (clk),
        .reset     (reset),
        .scl       (bus.i2c_scl),
        .sda       (bus.i2c_sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign byte_done = (bit_cnt == 4'd8);

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Bus conditions override any bit-level progress; state only advances on SCL falls.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (stop_det) begin
            state_nxt = ST_IDLE;
        end else if (start_det) begin
            state_nxt = ST_ADDR;
        end else if (scl_fall) begin
            case (state)
                ST_ADDR:     if (byte_done) state_nxt = (shift[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: state_nxt = rw ? ST_RD_BYTE : ST_WR_BYTE;
                ST_WR_BYTE:  if (byte_done) state_nxt = ST_WR_ACK;
                ST_WR_ACK:   state_nxt = ST_WR_BYTE;
                ST_RD_BYTE:  if (byte_done) state_nxt = ST_RD_ACK;
                ST_RD_ACK:   state_nxt = master_ack ? ST_RD_BYTE : ST_IDLE_WAIT;
                default:     state_nxt = state;
            endcase
        end
    end

    // Decoded from registered state so reset releases SDA without waiting for a clock.
    always_comb begin
        sda_dir = 1'b0;
        case (state)
            ST_ADDR_ACK, ST_WR_ACK: sda_dir = 1'b1;
            ST_RD_BYTE:             sda_dir = ~shift[7];
            default:                sda_dir = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift      <= '0;
            pointer    <= '0;
            bit_cnt    <= '0;
            rw         <= 1'b0;
            byte_index <= 1'b0;
            master_ack <= 1'b0;
            snap       <= '0;
            cfg_we     <= 1'b0;
            cfg_addr   <= '0;
            cfg_data   <= '0;
            cfg_30     <= '0;
            cfg_33     <= '0;
        end else begin
            cfg_we <= 1'b0;
            if (start_det || stop_det) begin
                bit_cnt <= '0;
            end else begin
                if (scl_rise) begin
                    case (state)
                        ST_ADDR, ST_WR_BYTE: if (!byte_done) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        ST_RD_BYTE: if (!byte_done) bit_cnt <= bit_cnt + 4'd1;
                        ST_RD_ACK: begin
                            master_ack <= ~sda_s;
                            if (!sda_s) pointer <= pointer + 8'd1;
                        end
                        default: ;
                    endcase
                end
                if (scl_fall) begin
                    case (state)
                        ST_ADDR: if (byte_done) begin
                            rw   <= shift[0];
                            snap <= {bus.blob_x, bus.blob_y, bus.blob_size, bus.blob_valid};
                        end
                        ST_ADDR_ACK: begin
                            bit_cnt    <= '0;
                            byte_index <= 1'b0;
                            if (rw) shift <= report_byte(pointer, READ_BASE, READ_LEN, snap);
                        end
                        ST_WR_BYTE: if (byte_done) begin
                            byte_index <= 1'b1;
                            if (!byte_index) begin
                                pointer <= shift;
                            end else begin
                                cfg_we   <= 1'b1;
                                cfg_addr <= pointer;
                                cfg_data <= shift;
                                if (pointer == REG_CONF_30) cfg_30 <= shift;
                                if (pointer == REG_MODE_33) cfg_33 <= shift;
                                pointer <= pointer + 8'd1;
                            end
                        end
                        ST_WR_ACK: bit_cnt <= '0;
                        ST_RD_BYTE: if (!byte_done && bit_cnt != 4'd0) shift <= {shift[6:0], 1'b0};
                        ST_RD_ACK: if (master_ack) begin
                            bit_cnt <= '0;
                            shift   <= report_byte(pointer, READ_BASE, READ_LEN, snap);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.i2c_sda     = 1'b0;
    assign bus.i2c_sda_dir = sda_dir;
    assign bus.cfg_we      = cfg_we;
    assign bus.cfg_addr    = cfg_addr;
    assign bus.cfg_data    = cfg_data;
    assign bus.cfg_30      = cfg_30;
    assign bus.cfg_33      = cfg_33;

endmodule

// File: tb/tb_camera_emulator.sv
// Bit-banged I2C master driving the camera emulator; a scoreboard checks ACKs, read bytes and cfg writes.
module tb_camera_emulator;
    import camera_pkg::*;

    localparam int QTR = 10;
    localparam logic [7:0] RPT_VALID [16] = '{8'h00, 8'hA5, 8'hC3, 8'h65,
                                              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cfg_pulses = 0;
    logic watch_drive = 1'b0;
    logic saw_drive = 1'b0;

    logic [7:0]  exp_q[$];
    string       name_q[$];
    logic [7:0]  obs_q[$];
    logic [15:0] cfg_exp_q[$];
    logic [15:0] cfg_e;
    logic [7:0]  obs_v, exp_v;
    string       exp_n;
    logic [7:0]  rd;

    camera_emulator_if bus();
    assign bus.i2c_scl    = scl_m;
    assign bus.i2c_sda_in = sda_m & ~bus.i2c_sda_dir;

    camera_emulator dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations as the DUT presents bytes, ACK bits and cfg writes.
    always @(negedge clk) begin
        if (watch_drive && bus.i2c_sda_dir) saw_drive = 1'b1;
        if (bus.cfg_we === 1'b1) begin
            cfg_pulses++;
            if (cfg_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL cfg_we: unexpected pulse addr=%02h data=%02h", bus.cfg_addr, bus.cfg_data);
            end else begin
                cfg_e = cfg_exp_q.pop_front();
                check("cfg_addr", {8'h00, bus.cfg_addr}, {8'h00, cfg_e[15:8]});
                check("cfg_data", {8'h00, bus.cfg_data}, {8'h00, cfg_e[7:0]});
            end
        end
        while (obs_q.size() > 0) begin
            obs_v = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: unexpected observation %02h", obs_v);
            end else begin
                exp_v = exp_q.pop_front();
                exp_n = name_q.pop_front();
                check(exp_n, {8'h00, obs_v}, {8'h00, exp_v});
            end
        end
    end

    task automatic quarter();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic expect_val(input string name, input logic [7:0] v);
        exp_q.push_back(v);
        name_q.push_back(name);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    quarter();
        scl_m = 1'b1; quarter(); quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        b = bus.i2c_sda_in; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        obs_q.push_back({7'd0, ~b});
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        obs_q.push_back(d);
        write_bit(nack);
    endtask

    // Pointer write followed by one data byte, all ACKed, producing one cfg_we pulse.
    task automatic write_txn(input logic [7:0] ptr, input logic [7:0] data);
        expect_val("addr ack", 8'h01);
        expect_val("ptr ack", 8'h01);
        expect_val("data ack", 8'h01);
        cfg_exp_q.push_back({ptr, data});
        i2c_start();
        write_byte(8'hB0);
        write_byte(ptr);
        write_byte(data);
        i2c_stop();
    endtask

    task automatic report_read(input logic valid_blob);
        expect_val("addr ack", 8'h01);
        expect_val("ptr ack", 8'h01);
        i2c_start();
        write_byte(8'hB0);
        write_byte(8'h36);
        i2c_start();
        expect_val("read addr ack", 8'h01);
        write_byte(8'hB1);
        for (int i = 0; i < 16; i++) begin
            expect_val("report byte", valid_blob ? RPT_VALID[i] : ((i == 0) ? 8'h00 : 8'hFF));
            read_byte(i == 15);
            if (i == 1) bus.blob_x = 10'h3FF;
        end
        check("sda released after nack", {15'd0, bus.i2c_sda_dir}, 16'h0000);
        i2c_stop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.blob_x = '0; bus.blob_y = '0; bus.blob_size = '0; bus.blob_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sda_dir", {15'd0, bus.i2c_sda_dir}, 16'h0000);
        check("reset i2c_sda", {15'd0, bus.i2c_sda}, 16'h0000);
        check("reset cfg_we", {15'd0, bus.cfg_we}, 16'h0000);
        check("reset cfg_addr", {8'h00, bus.cfg_addr}, 16'h0000);
        check("reset cfg_data", {8'h00, bus.cfg_data}, 16'h0000);
        check("reset cfg_30", {8'h00, bus.cfg_30}, 16'h0000);
        check("reset cfg_33", {8'h00, bus.cfg_33}, 16'h0000);
        check("reset state", 16'(dut.state), 16'(ST_IDLE));
        check("reset pointer", {8'h00, dut.pointer}, 16'h0000);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        write_txn(8'h30, 8'h01);
        check("cfg_30 after first write", {8'h00, bus.cfg_30}, 16'h0001);

        cfg_pulses = 0;
        write_txn(8'h30, 8'h01);
        write_txn(8'h30, 8'h08);
        write_txn(8'h33, 8'h33);
        quarter();
        check("cfg_we pulse count", 16'(cfg_pulses), 16'd3);
        check("cfg_30 after config", {8'h00, bus.cfg_30}, 16'h0008);
        check("cfg_33 after config", {8'h00, bus.cfg_33}, 16'h0033);

        bus.blob_x = 10'h2A5; bus.blob_y = 10'h1C3; bus.blob_size = 4'd5; bus.blob_valid = 1'b1;
        report_read(1'b1);
        bus.blob_x = 10'h2A5; bus.blob_valid = 1'b0;
        report_read(1'b0);

        // Foreign address: never ACKed, SDA never driven.
        saw_drive = 1'b0;
        watch_drive = 1'b1;
        expect_val("foreign addr nack", 8'h00);
        expect_val("foreign data nack", 8'h00);
        i2c_start();
        write_byte(8'h42);
        write_byte(8'h00);
        i2c_stop();
        watch_drive = 1'b0;
        check("sda driven for foreign addr", {15'd0, saw_drive}, 16'h0000);
        write_txn(8'h40, 8'h77);

        // Pointer wraps 0xFF -> 0x00 during a burst write.
        expect_val("addr ack", 8'h01);
        expect_val("ptr ack", 8'h01);
        expect_val("data ack", 8'h01);
        expect_val("data ack", 8'h01);
        cfg_exp_q.push_back(16'hFFAA);
        cfg_exp_q.push_back(16'h00BB);
        i2c_start();
        write_byte(8'hB0);
        write_byte(8'hFF);
        write_byte(8'hAA);
        write_byte(8'hBB);
        i2c_stop();

        // First pointer past the report window reads 0x00.
        bus.blob_valid = 1'b1;
        expect_val("addr ack", 8'h01);
        expect_val("ptr ack", 8'h01);
        expect_val("read addr ack", 8'h01);
        expect_val("past window byte", 8'h00);
        i2c_start();
        write_byte(8'hB0);
        write_byte(8'h46);
        i2c_start();
        write_byte(8'hB1);
        read_byte(1'b1);
        i2c_stop();

        // Reset while RD_BYTE drives a 0.
        expect_val("addr ack", 8'h01);
        expect_val("ptr ack", 8'h01);
        expect_val("read addr ack", 8'h01);
        i2c_start();
        write_byte(8'hB0);
        write_byte(8'h36);
        i2c_start();
        write_byte(8'hB1);
        check("driving read bit 0", {15'd0, bus.i2c_sda_dir}, 16'h0001);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("sda_dir async release", {15'd0, bus.i2c_sda_dir}, 16'h0000);
        check("state after mid reset", 16'(dut.state), 16'(ST_IDLE));
        check("pointer after mid reset", {8'h00, dut.pointer}, 16'h0000);
        check("cfg_30 after mid reset", {8'h00, bus.cfg_30}, 16'h0000);
        @(negedge clk);
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
        reset = 1'b1; quarter();
        write_txn(8'h30, 8'h05);
        check("cfg_30 after recovery", {8'h00, bus.cfg_30}, 16'h0005);

        for (int i = 0; i < 100 && obs_q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("pending expected values", 16'(exp_q.size()), 16'd0);
        check("pending cfg writes", 16'(cfg_exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
